word_to_byte_reader: RTL and testbench
======================================

# word_to_byte_reader

Streams a range of bytes out of word-organized memory, one byte per valid/ready handshake, for UART readback of program/data memory. It is the read-side counterpart of the byte-to-word write path. It issues word reads with a word address, buffers each fetched word, and emits its bytes in ascending address order, little-endian lane order. Each word is fetched once per pass.

## Interface
Parameters:
- BYTE_ADDR_WIDTH, 6, width of byte address (default 64 bytes).
- BYTES_PER_WORD, 4, bytes per word; power of 2. Derived: LOG2 = $clog2(BYTES_PER_WORD), WORD_BITS = 8*BYTES_PER_WORD.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; ignored while busy.
- start_addr  in  BYTE_ADDR_WIDTH  first byte address, sampled with start.
- byte_count  in  BYTE_ADDR_WIDTH+1  bytes to send (0..2^BYTE_ADDR_WIDTH), sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- mem_rd_en  out  1  word read strobe.
- mem_word_addr  out  BYTE_ADDR_WIDTH-LOG2  word address, valid with mem_rd_en.
- mem_rd_data  in  WORD_BITS  read data, valid the cycle after mem_rd_en.
- byte_valid  out  1  byte_data valid.
- byte_data  out  8  output byte.
- byte_ready  in  1  consumer accepts byte when high with byte_valid.

## Operation
- States: IDLE, FETCH, WAIT, SEND.
- IDLE: if start, latch addr and count. Count 0: go to IDLE, pulse done, no memory read. Otherwise go to FETCH with busy=1.
- FETCH: mem_rd_en=1 for exactly one cycle, mem_word_addr=addr[BYTE_ADDR_WIDTH-1:LOG2]. Next state WAIT.
- WAIT: capture mem_rd_data into the word buffer. Next state SEND.
- SEND: byte_valid=1, byte_data=buffer[8*addr[LOG2-1:0] +: 8].
  - On handshake: count−1 and addr+1, with addr wrapping modulo 2^BYTE_ADDR_WIDTH.
  - If the new count is 0: go to IDLE, pulse done, busy=0.
  - Else if the new addr[LOG2-1:0]==0 (word boundary, including wrap to 0): go to FETCH.
  - Else stay in SEND and present the next lane.
- byte_valid is never withdrawn without a handshake. byte_data is stable while byte_valid && !byte_ready.
- start during busy has no effect. There is no abort input.

## Timing
- Reset (async, immediate): state IDLE; busy, done, mem_rd_en, byte_valid = 0; byte_data, mem_word_addr = 0; buffer, addr, and count cleared. Reset mid-transfer drops the transfer with no done pulse.
- Latency:
  - Start sampled at edge E0.
  - mem_rd_en high in cycle E0..E1.
  - Capture in E1..E2.
  - First byte_valid from E2 onward, i.e. three cycles after start.
- Throughput:
  - Within a word with byte_ready held high, one byte per cycle.
  - At a word boundary, a 2-cycle bubble (FETCH, WAIT) between bytes.
- All outputs are registered or derived only from registered state. There are no combinational paths from byte_ready or start to outputs.
- done and busy=0 appear in the cycle after the final handshake. A start in that same cycle is accepted.

## Structure
- Shared package/header `byte_word_defs`: BYTES_PER_WORD default, LOG2 derivation, and the state encoding (2-bit: IDLE=0, FETCH=1, WAIT=2, SEND=3).
- One natural sub-module: `word_lane_select`, a combinational byte-lane mux (word, lane index → byte). The FSM, counters, and buffer stay in the top module.

## Test plan
Memory model: word0=0x44332211, word1=0x88776655, word15=0xFFEEDDCC, 1-cycle read latency.
- Aligned read: start_addr=0, count=8, byte_ready=1 → bytes 11,22,33,44,55,66,77,88. Exactly 2 mem_rd_en pulses (addr 0, then 1). First valid 3 cycles after start. 2-cycle gap between 44 and 55. One done pulse.
- Unaligned plus wrap: start_addr=62, count=4 → bytes EE,FF,11,22. Word reads at addr 15 then 0.
- Backpressure: start_addr=1, count=2, byte_ready low for 5 cycles → byte_data holds 22 with valid high throughout. Then 33 follows. Done only after the second handshake.
- Zero count and start while busy: count=0 → done pulse, no mem_rd_en, no byte_valid. A second start during an active 4-byte transfer is ignored; the byte count stays 4.
- Async reset in SEND: assert rst_n=0 mid-word → busy, byte_valid, and mem_rd_en go 0 without waiting for a clock edge; no done pulse. After release, a new start works normally.
- Full range: start_addr=0, count=64 → 64 bytes in address order, 16 word reads, then done.

Source files
------------

// File: rtl/byte_word_defs_pkg.sv
// Shared definitions for the byte/word memory access paths: word geometry and
// the reader FSM state encoding.
package byte_word_defs;

    localparam int unsigned BYTES_PER_WORD_DEFAULT = 4;

    // Number of byte-lane index bits for a power-of-two word size.
    function automatic int unsigned lane_bits(input int unsigned bytes_per_word);
        return $clog2(bytes_per_word);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_e;

endpackage

// File: rtl/word_to_byte_reader_lane_select.sv
// Combinational byte-lane mux: picks one little-endian byte out of a word.
module word_lane_select
    import byte_word_defs::*;
#(
    parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEFAULT,
    parameter int unsigned LANE_W         = 2
) (
    input  logic [8*BYTES_PER_WORD-1:0] word,
    input  logic [LANE_W-1:0]           lane,
    output logic [7:0]                  lane_byte_c
);

    always_comb begin
        lane_byte_c = 8'h00;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            if (LANE_W'(i) == lane) begin
                lane_byte_c = word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/word_to_byte_reader.sv
// Streams a byte range out of word-organized memory: one word read per word,
// bytes emitted in ascending address order over a valid/ready handshake.
module word_to_byte_reader
    import byte_word_defs::*;
#(
    parameter int unsigned BYTE_ADDR_WIDTH = 6,
    parameter int unsigned BYTES_PER_WORD  = BYTES_PER_WORD_DEFAULT
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             start,
    input  logic [BYTE_ADDR_WIDTH-1:0]                       start_addr,
    input  logic [BYTE_ADDR_WIDTH:0]                         byte_count,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             mem_rd_en,
    output logic [BYTE_ADDR_WIDTH-lane_bits(BYTES_PER_WORD)-1:0] mem_word_addr,
    input  logic [8*BYTES_PER_WORD-1:0]                      mem_rd_data,
    output logic                                             byte_valid,
    output logic [7:0]                                       byte_data,
    input  logic                                             byte_ready
);

    localparam int unsigned LOG2      = lane_bits(BYTES_PER_WORD);
    localparam int unsigned WORD_BITS = 8 * BYTES_PER_WORD;
    localparam int unsigned WADDR_W   = BYTE_ADDR_WIDTH - LOG2;
    localparam int unsigned COUNT_W   = BYTE_ADDR_WIDTH + 1;

    state_e                     state, state_d;
    logic [BYTE_ADDR_WIDTH-1:0] addr, addr_d;
    logic [COUNT_W-1:0]         count, count_d;
    logic [WORD_BITS-1:0]       word_buf, word_buf_d;
    logic                       busy_d, done_d, rd_en_d, valid_d;
    logic [WADDR_W-1:0]         word_addr_d;
    logic [7:0]                 data_d;

    logic [BYTE_ADDR_WIDTH-1:0] addr_inc_c;
    logic [COUNT_W-1:0]         count_dec_c;
    logic [WORD_BITS-1:0]       sel_word_c;
    logic [LOG2-1:0]            sel_lane_c;
    logic [7:0]                 lane_byte_c;

    assign addr_inc_c  = addr + BYTE_ADDR_WIDTH'(1);
    assign count_dec_c = count - COUNT_W'(1);

    // In WAIT the first byte comes straight from the returning word; in SEND
    // the next lane comes from the buffer at the post-handshake address.
    assign sel_word_c = (state == WAIT) ? mem_rd_data : word_buf;
    assign sel_lane_c = (state == WAIT) ? addr[LOG2-1:0] : addr_inc_c[LOG2-1:0];

    word_lane_select #(
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .LANE_W         (LOG2)
    ) u_lane_select (
        .word        (sel_word_c),
        .lane        (sel_lane_c),
        .lane_byte_c (lane_byte_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            count         <= '0;
            word_buf      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_word_addr <= '0;
            byte_valid    <= 1'b0;
            byte_data     <= 8'h00;
        end else begin
            state         <= state_d;
            addr          <= addr_d;
            count         <= count_d;
            word_buf      <= word_buf_d;
            busy          <= busy_d;
            done          <= done_d;
            mem_rd_en     <= rd_en_d;
            mem_word_addr <= word_addr_d;
            byte_valid    <= valid_d;
            byte_data     <= data_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        addr_d      = addr;
        count_d     = count;
        word_buf_d  = word_buf;
        busy_d      = busy;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        word_addr_d = mem_word_addr;
        valid_d     = byte_valid;
        data_d      = byte_data;

        unique case (state)
            IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    count_d = byte_count;
                    if (byte_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = FETCH;
                        busy_d      = 1'b1;
                        rd_en_d     = 1'b1;
                        word_addr_d = start_addr[BYTE_ADDR_WIDTH-1:LOG2];
                    end
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                word_buf_d = mem_rd_data;
                data_d     = lane_byte_c;
                valid_d    = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (byte_ready) begin
                    addr_d  = addr_inc_c;
                    count_d = count_dec_c;
                    if (count_dec_c == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                    end else if (addr_inc_c[LOG2-1:0] == '0) begin
                        // Word boundary (including wrap to address 0).
                        state_d     = FETCH;
                        rd_en_d     = 1'b1;
                        word_addr_d = addr_inc_c[BYTE_ADDR_WIDTH-1:LOG2];
                        valid_d     = 1'b0;
                    end else begin
                        data_d = lane_byte_c;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_word_to_byte_reader.sv
// Directed bench for word_to_byte_reader with a 1-cycle-latency word memory.
module tb_word_to_byte_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] start_addr;
    logic [6:0] byte_count;
    logic       busy, done, mem_rd_en, byte_valid, byte_ready;
    logic [3:0] mem_word_addr;
    logic [31:0] mem_rd_data;
    logic [7:0] byte_data;

    word_to_byte_reader #(
        .BYTE_ADDR_WIDTH (6),
        .BYTES_PER_WORD  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_addr    (start_addr),
        .byte_count    (byte_count),
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_word_addr (mem_word_addr),
        .mem_rd_data   (mem_rd_data),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc;

    logic [31:0] mem_words [16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rd_data <= mem_words[mem_word_addr];
    end

    // Observation log, sampled mid-cycle.
    logic [7:0] got_q [$];
    int         got_cyc [$];
    int         rd_addr_q [$];
    int         rd_cyc_q [$];
    int         done_cnt, done_cyc, first_valid, valid_cnt;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                rd_addr_q.push_back(int'(mem_word_addr));
                rd_cyc_q.push_back(cyc);
            end
            if (byte_valid && first_valid < 0) first_valid = cyc;
            if (byte_valid) valid_cnt++;
            if (byte_valid && byte_ready) begin
                got_q.push_back(byte_data);
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        got_q.delete();
        got_cyc.delete();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        first_valid = -1;
        valid_cnt   = 0;
    endtask

    task automatic go(input logic [5:0] a, input logic [6:0] n);
        @(posedge clk);
        #1;
        clear_mon();
        start      = 1'b1;
        start_addr = a;
        byte_count = n;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        byte_count = '0;
        byte_ready = 1'b0;
        #3;
        n_cmp++;
        if ({busy, done, mem_rd_en, byte_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, mem_rd_en, byte_valid});
        end
        n_cmp++;
        if ({byte_data, mem_word_addr} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 000", {byte_data, mem_word_addr});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic test_aligned();
        logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        byte_ready = 1'b1;
        go(6'd0, 7'd8);
        wait_done("aligned", 40);
        n_cmp++;
        if (got_q.size() != 8) begin
            n_bad++;
            $display("FAIL aligned_len: got %0d want 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL aligned_byte%0d: got %h want %h", i, got_q[i], exp[i]);
            end
        end
        n_cmp++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] != 0 || rd_addr_q[1] != 1) begin
            n_bad++;
            $display("FAIL aligned_reads: got %0d reads want 2 (addr 0,1)", rd_addr_q.size());
        end
        n_cmp++;
        if (rd_cyc_q.size() < 1 || rd_cyc_q[0] - start_cyc != 0) begin
            n_bad++;
            $display("FAIL aligned_rd_latency: got %0d want 0", rd_cyc_q.size() < 1 ? -1 : rd_cyc_q[0] - start_cyc);
        end
        n_cmp++;
        if (first_valid - start_cyc != 2) begin
            n_bad++;
            $display("FAIL aligned_valid_latency: got %0d want 2", first_valid - start_cyc);
        end
        if (got_cyc.size() == 8) begin
            n_cmp++;
            if (got_cyc[4] - got_cyc[3] != 3) begin
                n_bad++;
                $display("FAIL aligned_boundary_gap: got %0d want 3", got_cyc[4] - got_cyc[3]);
            end
            n_cmp++;
            if (done_cyc != got_cyc[7] + 1) begin
                n_bad++;
                $display("FAIL aligned_done_cycle: got %0d want %0d", done_cyc, got_cyc[7] + 1);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL aligned_done: got done_cnt=%0d busy=%b want 1,0", done_cnt, busy);
        end
    endtask

    task automatic test_unaligned_wrap();
        logic [7:0] exp [4] = '{8'hEE, 8'hFF, 8'h11, 8'h22};
        byte_ready = 1'b1;
        go(6'd62, 7'd4);
        wait_done("wrap", 40);
        n_cmp++;
        if (got_q.size() != 4) begin
            n_bad++;
            $display("FAIL wrap_len: got %0d want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL wrap_byte%0d: got %h want %h", i, got_q[i], exp[i]);
            end
        end
        n_cmp++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] != 15 || rd_addr_q[1] != 0) begin
            n_bad++;
            $display("FAIL wrap_reads: got %0d reads want 2 (addr 15,0)", rd_addr_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        byte_ready = 1'b0;
        go(6'd1, 7'd2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (byte_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL bp_valid_timeout: byte_valid never rose");
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (byte_valid !== 1'b1 || byte_data !== 8'h22 || done_cnt != 0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h done_cnt=%0d want 1,22,0",
                         k, byte_valid, byte_data, done_cnt);
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        byte_ready = 1'b1;
        wait_done("bp", 20);
        n_cmp++;
        if (got_q.size() != 2 || got_q[0] !== 8'h22 || got_q[1] !== 8'h33) begin
            n_bad++;
            $display("FAIL bp_bytes: got %0d bytes want 22,33", got_q.size());
        end
        n_cmp++;
        if (done_cnt != 1 || got_cyc.size() != 2 || done_cyc != got_cyc[1] + 1) begin
            n_bad++;
            $display("FAIL bp_done: got done_cnt=%0d done_cyc=%0d want 1 after last handshake",
                     done_cnt, done_cyc);
        end
    endtask

    task automatic test_zero_and_busy_start();
        byte_ready = 1'b1;
        go(6'd8, 7'd0);
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (done_cnt != 1 || rd_addr_q.size() != 0 || valid_cnt != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_count: got done=%0d reads=%0d valid=%0d busy=%b want 1,0,0,0",
                     done_cnt, rd_addr_q.size(), valid_cnt, busy);
        end
        go(6'd0, 7'd4);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 6'd32;
        byte_count = 7'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_start", 30);
        n_cmp++;
        if (got_q.size() != 4 || rd_addr_q.size() != 1 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL busy_start: got bytes=%0d reads=%0d done=%0d want 4,1,1",
                     got_q.size(), rd_addr_q.size(), done_cnt);
        end
        n_cmp++;
        if (got_q.size() == 4 && got_q[3] !== 8'h44) begin
            n_bad++;
            $display("FAIL busy_start_last: got %h want 44", got_q[3]);
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        byte_ready = 1'b1;
        go(6'd0, 7'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL b2b_first_done: done never pulsed");
        end
        start      = 1'b1;
        start_addr = 6'd4;
        byte_count = 7'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != 2 || got_q[0] !== 8'h11 || got_q[1] !== 8'h55 || done_cnt != 2) begin
            n_bad++;
            $display("FAIL b2b: got bytes=%0d done=%0d want 11,55 and 2 dones", got_q.size(), done_cnt);
        end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        byte_ready = 1'b0;
        go(6'd0, 7'd8);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (byte_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL arst_valid_timeout: byte_valid never rose");
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, byte_valid, mem_rd_en, done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL arst_immediate: got %b want 0000", {busy, byte_valid, mem_rd_en, done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_no_done: got done_cnt=%0d busy=%b want 0,0", done_cnt, busy);
        end
        byte_ready = 1'b1;
        go(6'd4, 7'd2);
        wait_done("arst_restart", 20);
        n_cmp++;
        if (got_q.size() != 2 || got_q[0] !== 8'h55 || got_q[1] !== 8'h66) begin
            n_bad++;
            $display("FAIL arst_restart: got %0d bytes want 55,66", got_q.size());
        end
    endtask

    task automatic test_full_range();
        logic [7:0] e;
        byte_ready = 1'b1;
        go(6'd0, 7'd64);
        wait_done("full", 200);
        n_cmp++;
        if (got_q.size() != 64 || rd_addr_q.size() != 16) begin
            n_bad++;
            $display("FAIL full_len: got bytes=%0d reads=%0d want 64,16", got_q.size(), rd_addr_q.size());
        end
        for (int a = 0; a < 64 && a < got_q.size(); a++) begin
            e = mem_words[a / 4][8*(a % 4) +: 8];
            n_cmp++;
            if (got_q[a] !== e) begin
                n_bad++;
                $display("FAIL full_byte%0d: got %h want %h", a, got_q[a], e);
            end
        end
        for (int w = 0; w < 16 && w < rd_addr_q.size(); w++) begin
            n_cmp++;
            if (rd_addr_q[w] != w) begin
                n_bad++;
                $display("FAIL full_read%0d: got %0d want %0d", w, rd_addr_q[w], w);
            end
        end
    endtask

    initial begin
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) mem_words[w][8*b +: 8] = 8'((4*w + b) * 3 + 7);
        end
        mem_words[0]  = 32'h44332211;
        mem_words[1]  = 32'h88776655;
        mem_words[15] = 32'hFFEEDDCC;
        mem_rd_data   = '0;
        clear_mon();

        test_reset();
        test_aligned();
        test_unaligned_wrap();
        test_backpressure();
        test_zero_and_busy_start();
        test_back_to_back();
        test_async_reset();
        test_full_range();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
